// File: rtl/mem_wb_stage_pkg.sv
// Shared control-bit indices, FSM encoding and pipeline bundles
// for the memory/writeback stage.
package mem_wb_stage_pkg;

   localparam int WB_REGWRITE = 0;
   localparam int WB_MEMTOREG = 1;

   localparam int M_MEMREAD  = 0;
   localparam int M_MEMWRITE = 1;
   localparam int M_BRANCH   = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } ex_mem_t;

   typedef struct packed {
      logic [1:0]  wb;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [4:0]  rd;
   } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory: asynchronous read,
// synchronous write gated by we.
module data_mem #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// EX/MEM register, latency-modelled data memory access,
// MEM/WB register and writeback mux.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int MEM_LAT = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  EXMWB,
   input  logic [2:0]  EXMM,
   input  logic [31:0] EXALUOut,
   input  logic [31:0] EXMWriteData,
   input  logic [4:0]  regtopass,
   output logic        stall,
   output logic [4:0]  EXMEMRegRd,
   output logic [1:0]  EXMEM_RegWrite,
   output logic [31:0] MEMALUOut,
   output logic [4:0]  MEMWBRegRd,
   output logic [1:0]  MEMWB_RegWrite,
   output logic [31:0] datatowrite
);

   localparam logic [3:0] LAT = 4'(MEM_LAT);

   ex_mem_t           em;
   mem_wb_t           mw;
   mem_state_e        state;
   mem_state_e        state_nx;
   logic [3:0]        cnt;
   logic [3:0]        cnt_nx;
   logic              mem_op;
   logic              is_load;
   logic              is_store;
   logic              done;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       mem_rdata;
   logic [31:0]       rdata;
   logic              unused_branch;

   // Both MemRead and MemWrite set behaves as a plain store.
   assign is_store = em.m[M_MEMWRITE];
   assign is_load  = em.m[M_MEMREAD] & ~em.m[M_MEMWRITE];
   assign mem_op   = is_store | is_load;
   assign addr     = em.alu[ADDR_W+1:2];
   assign we       = done & is_store;
   assign rdata    = is_load ? mem_rdata : 32'd0;

   assign unused_branch = em.m[M_BRANCH];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      stall    = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (mem_op && (LAT != 4'd0)) begin
               stall    = 1'b1;
               state_nx = BUSY;
               cnt_nx   = 4'd1;
            end else begin
               done = 1'b1;
            end
         end
         BUSY: begin
            if (cnt < LAT) begin
               stall  = 1'b1;
               cnt_nx = cnt + 4'd1;
            end else begin
               done     = 1'b1;
               state_nx = IDLE;
               cnt_nx   = 4'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         em    <= '0;
         mw    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (!stall) begin
            em <= '{wb: EXMWB, m: EXMM, alu: EXALUOut,
                    wdata: EXMWriteData, rd: regtopass};
            mw <= '{wb: em.wb, alu: em.alu,
                    rdata: rdata, rd: em.rd};
         end
      end
   end

   data_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clock (clock),
      .we    (we),
      .addr  (addr),
      .wdata (em.wdata),
      .rdata (mem_rdata)
   );

   assign EXMEMRegRd     = em.rd;
   assign EXMEM_RegWrite = {1'b0, em.wb[WB_REGWRITE]};
   assign MEMALUOut      = em.alu;
   assign MEMWBRegRd     = mw.rd;
   assign MEMWB_RegWrite = {1'b0, mw.wb[WB_REGWRITE]};
   assign datatowrite    = mw.wb[WB_MEMTOREG] ? mw.rdata : mw.alu;

endmodule
